dds_freq_meter: RTL and testbench
=================================

Name: dds_freq_meter

Overview:
- Measures the frequency of a sampled sinusoid, such as the DDS sine output, and returns the equivalent M-bit DDS phase increment (tuning word).
- It is the receive-side counterpart of the DDS generator: tuning word in there, tuning word recovered here.
- Counts valid samples over N_PER rising zero crossings, then runs a sequential divide: est = floor(N_PER * 2^M / C).
- Used for loopback self-check and for frequency tracking of external tones.

Parameters:
- M, 32: tuning-word wordlength, U[M,0].
- W, 14: input sample wordlength, S[W,W-1].
- K, 4: log2 of the number of averaged periods; N_PER = 2^K.
- CNT_W, 24: sample-counter wordlength, U[CNT_W,0].

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- ic_rst  in  1  synchronous, active-high reset.
- ic_en  in  1  measurement enable.
- id_wave  in  W  input sample, signed S[W,W-1].
- ic_val_data  in  1  id_wave valid this cycle.
- od_p_est  out  M  estimated phase increment, U[M,0]; held between results.
- oc_val_est  out  1  one-cycle pulse; od_p_est and oc_ovf are valid.
- oc_ovf  out  1  qualifies the current result as invalid (counter overflow); held with od_p_est.
- oc_busy  out  1  high in states ARM, COUNT and DIV.

Behaviour:
- Reset (ic_rst=1 at a clock edge) has priority over everything, including mid-division:
  - state=IDLE; od_p_est=0, oc_val_est=0, oc_ovf=0, oc_busy=0.
  - Sample counter, crossing counter and divider registers cleared; previous-sample-valid flag cleared.
- Rising crossing: an accepted sample (ic_val_data=1) with sign bit 0, when the previous accepted sample had sign bit 1.
  - Cycles with ic_val_data=0 are ignored entirely: no count, and the previous sample is not updated.
  - No crossing is possible until one sample has been accepted since entering ARM.
- States:
  - IDLE: wait. When ic_en=1 -> ARM, with the previous-sample-valid flag cleared.
  - ARM: accept samples; on the first rising crossing -> COUNT with C=0 and crossings=0. That start sample is not counted.
  - COUNT: each accepted sample increments C, including the terminal-crossing sample. Each rising crossing increments the crossing count. The sample giving crossing number N_PER -> DIV.
  - DIV: exactly M cycles. Produces quotient bits M-1..0 of 2^(M+K)/C, one bit per cycle, restoring algorithm.
    - Saturation pre-check on entry: if C <= 2^K, force the result to 2^M-1 and still spend M cycles.
  - DONE: single cycle.
    - oc_val_est=1; od_p_est and oc_ovf are updated on the edge entering DONE.
    - Then -> ARM if ic_en=1, else -> IDLE.
- Latency: oc_val_est is high in the cycle starting M+1 clock edges after the edge that registered the terminal crossing sample.
- Counter overflow: an accepted sample in COUNT while C = 2^CNT_W-1 forces DONE on the next edge with od_p_est=0 and oc_ovf=1. oc_ovf=0 on every normal result.
- ic_en=0 in ARM or COUNT: -> IDLE on that edge, no result; od_p_est keeps its previous value.
- ic_en=0 during DIV or DONE: the division completes, the result is published, then -> IDLE.
- Samples arriving during DIV/DONE are discarded and the previous-sample-valid flag is cleared, so a new measurement starts from a fresh crossing.
- Sample value 0 counts as non-negative.

Test Plan:
1. DDS loopback, p=0x2000_0000 (8 samples/period), continuous valid -> C=128; od_p_est=0x2000_0000, oc_ovf=0; oc_val_est exactly M+1=33 edges after the 16th crossing sample.
2. DDS loopback, p=0x0100_0000 (256 samples/period) -> C=4096; od_p_est=0x0100_0000. Repeat with ic_val_data toggling 1/0 every cycle -> identical result, with each measurement taking twice as many clocks.
3. p=0x0147_AE14 (~200 samples/period) -> od_p_est within ±0x2000 of 0x0147_AE14; consecutive results pulse continuously while ic_en=1.
4. CNT_W=10, p=0x0100_0000 -> C reaches 1023; result od_p_est=0, oc_ovf=1, pulse one cycle; the next result is the same while ic_en stays high.
5. ic_en dropped mid-COUNT -> no oc_val_est, od_p_est unchanged, oc_busy=0 on the next cycle. ic_rst asserted mid-DIV -> all outputs 0 on the next edge, no pulse; after release with ic_en=1, a correct result follows.
6. Constant input of -1 then a step to +1 at a single transition, K=0, positive for 3 samples then negative -> no result until a second rising crossing; verify no crossing is detected on the first sample after ARM entry.

Source files
------------

// File: rtl/dds_freq_meter_if.sv
// rtl/dds_freq_meter_if.sv - sample stream in, tuning-word estimate out
interface dds_freq_meter_if #(
    parameter int M = 32,
    parameter int W = 14
);
    logic                ic_en;
    logic signed [W-1:0] id_wave;
    logic                ic_val_data;
    logic [M-1:0]        od_p_est;
    logic                oc_val_est;
    logic                oc_ovf;
    logic                oc_busy;

    modport master (
        output ic_en, id_wave, ic_val_data,
        input  od_p_est, oc_val_est, oc_ovf, oc_busy
    );

    modport slave (
        input  ic_en, id_wave, ic_val_data,
        output od_p_est, oc_val_est, oc_ovf, oc_busy
    );
endinterface

// File: rtl/dds_freq_meter.sv
// rtl/dds_freq_meter.sv - zero-crossing period counter with restoring divide to a DDS tuning word
module dds_freq_meter #(
    parameter int M     = 32,
    parameter int W     = 14,
    parameter int K     = 4,
    parameter int CNT_W = 24
) (
    input  logic              clk,
    input  logic              ic_rst,
    dds_freq_meter_if.slave   bus
);
    localparam int N_PER = 1 << K;
    localparam int XW    = K + 1;
    localparam int RW    = CNT_W + 1;
    localparam int BW    = (M > 1) ? $clog2(M) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] N_PER_C   = CNT_W'(N_PER);
    localparam logic [XW-1:0]    X_LAST    = XW'(N_PER - 1);
    localparam logic [RW-1:0]    REM_INIT  = RW'(N_PER);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(M - 1);

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DIV, DONE} state_t;

    state_t             state_q;
    logic               val_q, sign_q;
    logic               prev_vld_q, prev_sign_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XW-1:0]      xcnt_q;
    logic [RW-1:0]      rem_q;
    logic [M-1:0]       quot_q;
    logic [BW-1:0]      bit_q;
    logic [M-1:0]       p_est_q;
    logic               val_est_q, ovf_q, busy_q;

    logic               rise_d;
    logic [RW-1:0]      rem2_d, rem_d;
    logic               ge_d;
    logic [M-1:0]       quot_d;
    logic               sat_d;

    // The dividend 2^(M+K) contributes only 2^K above the quotient field, so the
    // remainder starts there and each step shifts in a zero bit.
    assign rise_d = val_q & prev_vld_q & prev_sign_q & ~sign_q;
    assign rem2_d = {rem_q[RW-2:0], 1'b0};
    assign ge_d   = (rem2_d >= {1'b0, cnt_q});
    assign rem_d  = ge_d ? (rem2_d - {1'b0, cnt_q}) : rem2_d;
    assign quot_d = {quot_q[M-2:0], ge_d};
    assign sat_d  = (cnt_q <= N_PER_C);

    always_ff @(posedge clk) begin
        if (ic_rst) begin
            state_q     <= IDLE;
            val_q       <= 1'b0;
            sign_q      <= 1'b0;
            prev_vld_q  <= 1'b0;
            prev_sign_q <= 1'b0;
            cnt_q       <= '0;
            xcnt_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            bit_q       <= '0;
            p_est_q     <= '0;
            val_est_q   <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            val_q     <= bus.ic_val_data;
            sign_q    <= bus.id_wave[W-1];
            val_est_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ic_en) begin
                        state_q    <= ARM;
                        busy_q     <= 1'b1;
                        prev_vld_q <= 1'b0;
                    end
                end
                ARM: begin
                    if (!bus.ic_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (val_q) begin
                        prev_vld_q  <= 1'b1;
                        prev_sign_q <= sign_q;
                        if (rise_d) begin
                            state_q <= COUNT;
                            cnt_q   <= '0;
                            xcnt_q  <= '0;
                        end
                    end
                end
                COUNT: begin
                    if (!bus.ic_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (val_q) begin
                        prev_vld_q  <= 1'b1;
                        prev_sign_q <= sign_q;
                        if (cnt_q == CNT_MAX) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            p_est_q   <= '0;
                            ovf_q     <= 1'b1;
                            val_est_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (rise_d) begin
                                if (xcnt_q == X_LAST) begin
                                    state_q <= DIV;
                                    rem_q   <= REM_INIT;
                                    quot_q  <= '0;
                                    bit_q   <= '0;
                                end else begin
                                    xcnt_q <= xcnt_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                DIV: begin
                    prev_vld_q <= 1'b0;
                    rem_q      <= rem_d;
                    quot_q     <= quot_d;
                    bit_q      <= bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        p_est_q   <= sat_d ? '1 : quot_d;
                        ovf_q     <= 1'b0;
                        val_est_q <= 1'b1;
                    end
                end
                DONE: begin
                    prev_vld_q <= 1'b0;
                    if (bus.ic_en) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.od_p_est   = p_est_q;
    assign bus.oc_val_est = val_est_q;
    assign bus.oc_ovf     = ovf_q;
    assign bus.oc_busy    = busy_q;
endmodule

// File: tb/tb_dds_freq_meter.sv
// tb/tb_dds_freq_meter.sv - scoreboard bench for dds_freq_meter
`timescale 1ns/1ps
module tb_dds_freq_meter;
    localparam int M = 32;
    localparam int W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic signed [W-1:0] wave = '0;
    logic val = 1'b0;

    dds_freq_meter_if #(.M(M), .W(W)) ifa ();
    dds_freq_meter_if #(.M(M), .W(W)) ifb ();
    dds_freq_meter_if #(.M(M), .W(W)) ifc ();

    assign ifa.ic_en = en_a; assign ifa.id_wave = wave; assign ifa.ic_val_data = val;
    assign ifb.ic_en = en_b; assign ifb.id_wave = wave; assign ifb.ic_val_data = val;
    assign ifc.ic_en = en_c; assign ifc.id_wave = wave; assign ifc.ic_val_data = val;

    dds_freq_meter #(.M(M), .W(W), .K(4), .CNT_W(24)) dut_a (.clk(clk), .ic_rst(rst), .bus(ifa));
    dds_freq_meter #(.M(M), .W(W), .K(4), .CNT_W(10)) dut_b (.clk(clk), .ic_rst(rst), .bus(ifb));
    dds_freq_meter #(.M(M), .W(W), .K(0), .CNT_W(24)) dut_c (.clk(clk), .ic_rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int           id;
        logic [M-1:0] est;
        logic [M-1:0] tol;
        logic         ovf;
        bit           lat;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];

    task automatic push(input int which, input int id, input logic [M-1:0] est,
                        input logic [M-1:0] tol, input logic ovf, input bit lat);
        exp_t e;
        e.id = id; e.est = est; e.tol = tol; e.ovf = ovf; e.lat = lat;
        case (which)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // DDS source: sine of an accumulating phase, advancing only on valid samples
    bit          gen_on = 1'b0;
    bit          tog = 1'b0;
    logic [31:0] pinc = '0;
    logic [31:0] ph = '0;

    function automatic logic signed [W-1:0] sine(input logic [31:0] p);
        real a;
        a = 8191.0 * $sin(6.283185307179586 * real'(p) / 4294967296.0);
        return W'($rtoi(a >= 0.0 ? a + 0.5 : a - 0.5));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (gen_on) begin
                if (tog && val) begin
                    val = 1'b0;
                end else begin
                    val  = 1'b1;
                    wave = sine(ph);
                    ph   = ph + pinc;
                end
            end
        end
    end

    // Independent crossing tracker: start crossing plus 16 more ends the first measurement
    bit tr_on = 1'b0;
    bit tp_ok = 1'b0;
    bit tp_neg = 1'b0;
    int tcross = 0;
    int term_edge = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tr_on && val) begin
                if (tp_ok && tp_neg && !wave[W-1]) tcross++;
                if (tcross == 17) begin
                    term_edge = cyc + 1;
                    tr_on = 1'b0;
                end
                tp_ok  = 1'b1;
                tp_neg = wave[W-1];
            end
        end
    end

    task automatic on_result(input int which, input logic [M-1:0] est, input logic ovf, input logic prev_pulse);
        exp_t e;
        int sz;
        logic [M-1:0] diff;
        sz = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
        check_eq($sformatf("dut%0d_sb_pending", which), sz != 0, 1);
        check_eq($sformatf("dut%0d_pulse_1cyc", which), prev_pulse, 0);
        if (sz != 0) begin
            case (which)
                0: e = qa.pop_front();
                1: e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            diff = (est > e.est) ? est - e.est : e.est - est;
            if (e.tol == 0)
                check_eq($sformatf("t%0d_est", e.id), est, e.est);
            else
                check_eq($sformatf("t%0d_est_in_tol(got 0x%0h)", e.id, est), diff <= e.tol, 1);
            check_eq($sformatf("t%0d_ovf", e.id), ovf, e.ovf);
            if (e.lat)
                check_eq($sformatf("t%0d_latency", e.id), cyc - term_edge, M + 1);
        end
    endtask

    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
    initial forever begin
        @(negedge clk);
        if (ifa.oc_val_est) on_result(0, ifa.od_p_est, ifa.oc_ovf, pa);
        pa = ifa.oc_val_est;
    end
    initial forever begin
        @(negedge clk);
        if (ifb.oc_val_est) on_result(1, ifb.od_p_est, ifb.oc_ovf, pb);
        pb = ifb.oc_val_est;
    end
    initial forever begin
        @(negedge clk);
        if (ifc.oc_val_est) on_result(2, ifc.od_p_est, ifc.oc_ovf, pc);
        pc = ifc.oc_val_est;
    end

    function automatic logic pulse_of(input int w);
        return (w == 0) ? ifa.oc_val_est : (w == 1) ? ifb.oc_val_est : ifc.oc_val_est;
    endfunction

    task automatic set_en(input int w, input logic v);
        case (w)
            0: en_a = v;
            1: en_b = v;
            default: en_c = v;
        endcase
    endtask

    task automatic wait_res(input int which, input int n, input int budget, input bit drop,
                            input string tag, output int t_last);
        int got;
        got = 0;
        t_last = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (pulse_of(which)) begin
                got++;
                t_last = cyc;
                if (got == n && drop) set_en(which, 1'b0);
            end
        end
        check_eq({tag, "_count"}, got, n);
    endtask

    task automatic step(input int v);
        @(posedge clk);
        #1;
        wave = W'(v);
        val  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_a_p_est", ifa.od_p_est, 0);
        check_eq("rst_a_val",   ifa.oc_val_est, 0);
        check_eq("rst_a_ovf",   ifa.oc_ovf, 0);
        check_eq("rst_a_busy",  ifa.oc_busy, 0);
        check_eq("rst_b_busy",  ifb.oc_busy, 0);
        check_eq("rst_c_busy",  ifc.oc_busy, 0);
        rst = 1'b0;

        // 8 samples/period, exact result and latency on the first measurement
        pinc = 32'h2000_0000; ph = '0; gen_on = 1'b1;
        push(0, 1, 32'h2000_0000, 0, 1'b0, 1'b1);
        push(0, 1, 32'h2000_0000, 0, 1'b0, 1'b0);
        push(0, 1, 32'h2000_0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        en_a = 1'b1; tr_on = 1'b1;
        wait_res(0, 3, 2000, 1'b1, "t1", t1);

        // 256 samples/period, continuous then half-rate valid
        repeat (5) @(posedge clk);
        pinc = 32'h0100_0000;
        push(0, 2, 32'h0100_0000, 0, 1'b0, 1'b0);
        push(0, 2, 32'h0100_0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1; en_a = 1'b1;
        wait_res(0, 1, 10000, 1'b0, "t2a", t0);
        wait_res(0, 1, 10000, 1'b1, "t2b", t1);
        check_eq("t2_cont_interval", (t1 - t0) >= 4096 && (t1 - t0) < 4500, 1);
        repeat (5) @(posedge clk);
        tog = 1'b1;
        push(0, 22, 32'h0100_0000, 0, 1'b0, 1'b0);
        push(0, 22, 32'h0100_0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1; en_a = 1'b1;
        wait_res(0, 1, 20000, 1'b0, "t2c", t0);
        wait_res(0, 1, 20000, 1'b1, "t2d", t1);
        check_eq("t2_toggle_interval", (t1 - t0) >= 8192 && (t1 - t0) < 9000, 1);
        tog = 1'b0;

        // enable dropped mid-count: no result, estimate held
        repeat (5) @(posedge clk);
        #1; en_a = 1'b1;
        repeat (1500) @(posedge clk);
        #1;
        check_eq("t5a_busy_in_count", ifa.oc_busy, 1);
        en_a = 1'b0;
        @(posedge clk); #1;
        check_eq("t5a_busy_after_drop", ifa.oc_busy, 0);
        check_eq("t5a_p_est_held", ifa.od_p_est, 32'h0100_0000);
        repeat (100) @(posedge clk);

        // non-integer period, tolerance check, back-to-back results
        pinc = 32'h0147_AE14;
        push(0, 3, 32'h0147_AE14, 32'h2000, 1'b0, 1'b0);
        push(0, 3, 32'h0147_AE14, 32'h2000, 1'b0, 1'b0);
        push(0, 3, 32'h0147_AE14, 32'h2000, 1'b0, 1'b0);
        @(posedge clk); #1; en_a = 1'b1;
        wait_res(0, 3, 12000, 1'b1, "t3", t1);

        // reset while dividing
        repeat (5) @(posedge clk);
        pinc = 32'h2000_0000;
        push(0, 5, 32'h2000_0000, 0, 1'b0, 1'b0);
        @(posedge clk); #1; en_a = 1'b1;
        wait_res(0, 1, 1000, 1'b0, "t5b_pre", t1);
        repeat (150) @(posedge clk);
        #1;
        check_eq("t5b_busy_in_div", ifa.oc_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t5b_rst_p_est", ifa.od_p_est, 0);
        check_eq("t5b_rst_val",   ifa.oc_val_est, 0);
        check_eq("t5b_rst_ovf",   ifa.oc_ovf, 0);
        check_eq("t5b_rst_busy",  ifa.oc_busy, 0);
        rst = 1'b0;
        push(0, 6, 32'h2000_0000, 0, 1'b0, 1'b0);
        wait_res(0, 1, 1000, 1'b1, "t5b_post", t1);

        // narrow counter overflows
        repeat (5) @(posedge clk);
        pinc = 32'h0100_0000;
        push(1, 4, 32'h0, 0, 1'b1, 1'b0);
        push(1, 4, 32'h0, 0, 1'b1, 1'b0);
        @(posedge clk); #1; en_b = 1'b1;
        wait_res(1, 2, 4000, 1'b1, "t4", t1);

        // K=0 single-period measurement from a hand-built waveform
        gen_on = 1'b0;
        repeat (3) @(posedge clk);
        push(2, 7, 32'((64'h1_0000_0000) / 27), 0, 1'b0, 1'b0);
        step(-1); en_c = 1'b1;
        step(-1); step(-1);
        step(1); step(1); step(1);
        for (int i = 0; i < 24; i++) step(-1);
        #1;
        check_eq("t6_busy_before_2nd_cross", ifc.oc_busy, 1);
        step(1);
        wait_res(2, 1, 100, 1'b1, "t6a", t1);

        // leave a negative previous sample behind, then re-arm on a positive sample
        repeat (3) @(posedge clk);
        step(-1); en_c = 1'b1;
        step(-1); step(-1); step(1); step(-1); step(-1);
        step(-1); en_c = 1'b0;
        step(-1); step(-1); step(-1);
        push(2, 8, 32'((64'h1_0000_0000) / 5), 0, 1'b0, 1'b0);
        step(1); en_c = 1'b1;
        step(1); step(-1); step(-1);
        step(1); step(1); step(-1); step(-1); step(-1);
        step(1);
        wait_res(2, 1, 100, 1'b1, "t6b", t1);

        repeat (10) @(posedge clk);
        check_eq("sb_a_drained", qa.size(), 0);
        check_eq("sb_b_drained", qb.size(), 0);
        check_eq("sb_c_drained", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
